// File: rtl/alg_unit_if.sv
// Control and result bundle between the EX stage and the multiply/divide engine.
// master drives the operation request; slave is the engine itself.
interface alg_unit_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [2:0]       op_x_bits;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  modport master (
    output start, op_x_bits, opa, opb, flush,
    input  stall, done, lo, hi
  );

  modport slave (
    input  start, op_x_bits, opa, opb, flush,
    output stall, done, lo, hi
  );
endinterface

// File: rtl/alg_unit.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) engine with a hi/lo result pair.
// One operand bit per cycle; stall holds the pipeline while iterating.
module alg_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter logic [2:0]  OP_MUL = 3'b011,
  parameter logic [2:0]  OP_DIV = 3'b101
) (
  input logic        clk,
  input logic        reset_n,
  alg_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] addend;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem;
  logic               last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    addend  = '0;
    trial   = '0;
    rem     = '0;
    last    = (cnt_q == CntW'(WIDTH - 1));

    unique case (state_q)
      StIdle, StDone: begin
        // DONE always leaves after one cycle; a valid start chains straight into the next op.
        state_d = StIdle;
        if (!bus.flush && bus.start && bus.op_x_bits == OP_MUL) begin
          state_d = StMul;
          a_d     = bus.opa;
          b_d     = bus.opb;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (!bus.flush && bus.start && bus.op_x_bits == OP_DIV) begin
          if (bus.opb == '0) begin
            state_d = StDone;
            lo_d    = '1;
            hi_d    = bus.opa;
          end else begin
            state_d = StDiv;
            a_d     = bus.opa;
            b_d     = bus.opb;
            acc_d   = {{WIDTH{1'b0}}, bus.opa};
            cnt_d   = '0;
          end
        end
      end
      StMul: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          if (b_q[cnt_q[CntW-2:0]]) addend = {{WIDTH{1'b0}}, a_q} << cnt_q;
          acc_d = acc_q + addend;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = StDone;
            cnt_d   = '0;
            hi_d    = acc_d[2*WIDTH-1:WIDTH];
            lo_d    = acc_d[WIDTH-1:0];
          end
        end
      end
      StDiv: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}.
          trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
          if (trial >= {1'b0, b_q}) begin
            rem   = trial[WIDTH-1:0] - b_q;
            acc_d = {rem, acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = StDone;
            cnt_d   = '0;
            hi_d    = acc_d[2*WIDTH-1:WIDTH];
            lo_d    = acc_d[WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.stall = (state_q == StMul) || (state_q == StDiv);
  assign bus.done  = (state_q == StDone);
  assign bus.lo    = lo_q;
  assign bus.hi    = hi_q;

endmodule

// File: tb/tb_alg_unit.sv
// Directed bench for alg_unit: multiply, divide, divide-by-zero, back-to-back, flush and reset.
// Inputs change 1ns after a rising edge; outputs are sampled in the same window.
module tb_alg_unit;

  localparam logic [2:0] OpMul = 3'b011;
  localparam logic [2:0] OpDiv = 3'b101;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  alg_unit_if #(.WIDTH(16)) bus ();

  alg_unit #(.WIDTH(16), .OP_MUL(OpMul), .OP_DIV(OpDiv)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation for one cycle; returns in cycle k+1 with start already low.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.start     = 1'b1;
    bus.op_x_bits = op;
    bus.opa       = a;
    bus.opb       = b;
    step();
    bus.start     = 1'b0;
    bus.op_x_bits = 3'b000;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.hi !== 16'h0000) begin bad++; $display("FAIL reset_hi: got %h want 0000", bus.hi); end
    total++; if (bus.lo !== 16'h0000) begin bad++; $display("FAIL reset_lo: got %h want 0000", bus.lo); end
    step();
  endtask

  task automatic test_mul_basic();
    issue(OpMul, 16'h012C, 16'h01F4);
    for (int i = 1; i <= 16; i++) begin
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL mul_stall k+%0d: got %b want 1", i, bus.stall); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mul_done_early k+%0d: got %b want 0", i, bus.done); end
      step();
    end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL mul_done: got %b want 1", bus.done); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL mul_stall_end: got %b want 0", bus.stall); end
    total++; if (bus.hi !== 16'h0002) begin bad++; $display("FAIL mul_hi: got %h want 0002", bus.hi); end
    total++; if (bus.lo !== 16'h49F0) begin bad++; $display("FAIL mul_lo: got %h want 49f0", bus.lo); end
    step();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse: got %b want 0", bus.done); end
    repeat (3) step();
    total++; if (bus.lo !== 16'h49F0) begin bad++; $display("FAIL mul_lo_hold: got %h want 49f0", bus.lo); end
  endtask

  task automatic test_back_to_back();
    issue(OpMul, 16'hFFFF, 16'hFFFF);
    for (int i = 1; i <= 16; i++) begin
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL b2b_mul_stall k+%0d: got %b want 1", i, bus.stall); end
      step();
    end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_mul_done: got %b want 1", bus.done); end
    total++; if (bus.hi !== 16'hFFFE) begin bad++; $display("FAIL b2b_mul_hi: got %h want fffe", bus.hi); end
    total++; if (bus.lo !== 16'h0001) begin bad++; $display("FAIL b2b_mul_lo: got %h want 0001", bus.lo); end
    issue(OpDiv, 16'h03E8, 16'h0007);
    for (int i = 1; i <= 16; i++) begin
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL b2b_div_stall k+%0d: got %b want 1", i, bus.stall); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_div_done_early k+%0d: got %b want 0", i, bus.done); end
      step();
    end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_div_done: got %b want 1", bus.done); end
    total++; if (bus.lo !== 16'h008E) begin bad++; $display("FAIL b2b_div_lo: got %h want 008e", bus.lo); end
    total++; if (bus.hi !== 16'h0006) begin bad++; $display("FAIL b2b_div_hi: got %h want 0006", bus.hi); end
    step();
  endtask

  task automatic test_div_zero();
    issue(OpDiv, 16'h1234, 16'h0000);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL div0_done: got %b want 1", bus.done); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL div0_stall: got %b want 0", bus.stall); end
    total++; if (bus.lo !== 16'hFFFF) begin bad++; $display("FAIL div0_lo: got %h want ffff", bus.lo); end
    total++; if (bus.hi !== 16'h1234) begin bad++; $display("FAIL div0_hi: got %h want 1234", bus.hi); end
    step();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL div0_done_pulse: got %b want 0", bus.done); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL div0_stall_after: got %b want 0", bus.stall); end
  endtask

  task automatic test_flush();
    issue(OpMul, 16'h012C, 16'h01F4);
    repeat (16) step();
    total++; if (bus.lo !== 16'h49F0) begin bad++; $display("FAIL flush_pre_lo: got %h want 49f0", bus.lo); end
    step();
    issue(OpDiv, 16'h03E8, 16'h0007);
    repeat (4) step();
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL flush_pre_stall: got %b want 1", bus.stall); end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", bus.stall); end
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL flush_done +%0d: got %b want 0", i, bus.done); end
      step();
    end
    total++; if (bus.hi !== 16'h0002) begin bad++; $display("FAIL flush_hi: got %h want 0002", bus.hi); end
    total++; if (bus.lo !== 16'h49F0) begin bad++; $display("FAIL flush_lo: got %h want 49f0", bus.lo); end
  endtask

  task automatic test_reset_mid();
    issue(OpMul, 16'h012C, 16'h01F4);
    repeat (7) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rmid_stall: got %b want 0", bus.stall); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", bus.done); end
    total++; if (bus.hi !== 16'h0000) begin bad++; $display("FAIL rmid_hi: got %h want 0000", bus.hi); end
    total++; if (bus.lo !== 16'h0000) begin bad++; $display("FAIL rmid_lo: got %h want 0000", bus.lo); end
    step();
    issue(OpMul, 16'h0003, 16'h0005);
    for (int i = 1; i <= 16; i++) begin
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rmid_mul_stall k+%0d: got %b want 1", i, bus.stall); end
      step();
    end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL rmid_mul_done: got %b want 1", bus.done); end
    total++; if (bus.hi !== 16'h0000) begin bad++; $display("FAIL rmid_mul_hi: got %h want 0000", bus.hi); end
    total++; if (bus.lo !== 16'h000F) begin bad++; $display("FAIL rmid_mul_lo: got %h want 000f", bus.lo); end
    step();
  endtask

  task automatic test_ignored();
    bus.flush = 1'b1;
    issue(OpMul, 16'h0101, 16'h0202);
    bus.flush = 1'b0;
    for (int i = 0; i < 18; i++) begin
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL ign_flush_stall +%0d: got %b want 0", i, bus.stall); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ign_flush_done +%0d: got %b want 0", i, bus.done); end
      step();
    end
    issue(3'b000, 16'h0101, 16'h0202);
    for (int i = 0; i < 18; i++) begin
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL ign_op_stall +%0d: got %b want 0", i, bus.stall); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ign_op_done +%0d: got %b want 0", i, bus.done); end
      step();
    end
    total++; if (bus.hi !== 16'h0000) begin bad++; $display("FAIL ign_hi: got %h want 0000", bus.hi); end
    total++; if (bus.lo !== 16'h000F) begin bad++; $display("FAIL ign_lo: got %h want 000f", bus.lo); end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.op_x_bits = 3'b000;
    bus.opa       = 16'h0000;
    bus.opb       = 16'h0000;
    bus.flush     = 1'b0;
    #1;
    test_reset();
    test_mul_basic();
    test_back_to_back();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
